id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage that registers decoded instructions and presents operands and control to the EX-stage ALU.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Inserts a one-cycle bubble on load-use hazards.
- Flushes itself when the ALU reports a taken branch or jump (branch_true).
- Sits between the decoder/register file and the ALU.

Parameters:
- DATA_W, 32, register/operand width (RegBus)
- ADDR_W, 32, instruction address width (InstAddrBus)
- ALUCTRL_W, 5, ALU control code width (AluCtrl)
- REG_IDX_W, 5, register index width
- CNT_W, 16, bubble performance counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decoder presents a valid instruction
- id_aluctrl  in  ALUCTRL_W  ALU operation
- id_rs1, id_rs2  in  REG_IDX_W  source register indices
- id_rs1_data, id_rs2_data  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign/zero-extended immediate
- id_use_imm  in  1  src2 comes from the immediate
- id_rd  in  REG_IDX_W  destination index
- id_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- id_pc  in  ADDR_W  instruction PC
- id_branch_off  in  ADDR_W  branch/jump offset
- mem_rd, mem_we, mem_is_load, mem_result  in  REG_IDX_W/1/1/DATA_W  EX/MEM stage writeback info
- wb_rd, wb_we, wb_data  in  REG_IDX_W/1/DATA_W  MEM/WB writeback info
- mem_stall  in  1  downstream stall; hold the stage
- branch_true  in  1  ALU taken-branch indication
- stall_id  out  1  freeze PC and the IF/ID register this cycle
- alu_enable  out  1  EX holds a valid instruction
- alu_aluctrl  out  ALUCTRL_W  registered ALU control
- alu_src1, alu_src2  out  DATA_W  forwarded ALU operands
- alu_pc_o, alu_branch_addr  out  ADDR_W  registered PC and offset
- ex_rd, ex_we, ex_is_load  out  REG_IDX_W/1/1  passed to EX/MEM
- ex_store_data  out  DATA_W  forwarded rs2, used as store data
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:

Reset:
- rst on a clock edge clears all registered state to 0.
- alu_enable=0, alu_aluctrl=AluCtrlNop (0), ex_we=0, bubble_cnt=0.

Register update, evaluated each clock edge in priority order rst > hold > flush > bubble > capture:
- Hold (mem_stall=1): all registers keep their value. branch_true is ignored while stalled; it is acted on in the first cycle with mem_stall=0.
- Flush (branch_true=1 and mem_stall=0): load a bubble. A bubble sets valid=0, aluctrl=Nop, we=0, is_load=0; the data fields are don't-care and are held at 0.
- Bubble (lu_hazard=1): load a bubble; bubble_cnt increments, saturating at all-ones.
- Capture: otherwise latch all id_* fields, with valid=id_valid.

Load-use hazard (combinational):
- lu_hazard = ex_valid & ex_is_load & ex_we & ex_rd!=0 & id_valid & (id_rs1==ex_rd | (!id_use_imm & id_rs2==ex_rd)).
- stall_id = (lu_hazard & !branch_true) | mem_stall.
- The stall lasts exactly one cycle; the load then sits in MEM and its data is forwarded from WB.

Forwarding (combinational, per source operand, register index r):
- r==0 → operand is 0.
- Else if mem_we & !mem_is_load & mem_rd==r → mem_result.
- Else if wb_we & wb_rd==r → wb_data.
- Else → the registered register-file data.
- The MEM source has priority over WB.
- A mem_is_load match is never forwarded from MEM; the interlock guarantees this case does not reach EX.

Operand outputs:
- alu_src1 = fwd(rs1).
- alu_src2 = use_imm ? imm : fwd(rs2).
- ex_store_data = fwd(rs2), regardless of use_imm.

Latency and timing:
- One cycle from id_* to alu_* outputs.
- Forwarding adds no cycles.
- Outputs are stable for the whole cycle, apart from the forward muxes following mem_*/wb_*.

Simultaneous events:
- branch_true and lu_hazard together: flush wins, stall_id=0, bubble_cnt unchanged.
- rst mid-stall: the stage returns to its reset state on that edge.

Decomposition:
- Shared package pipe_pkg holds:
  - RegBus/InstAddrBus/AluCtrl widths.
  - The AluCtrl enum, including AluCtrlNop=0.
  - A typedef struct id_ex_t with fields valid, aluctrl, rs1, rs2, rs1_data, rs2_data, imm, use_imm, rd, we, is_load, pc, branch_off.
- Sub-module fwd_unit: pure combinational forwarding for one operand, instantiated twice.

Test Plan:
- Reset: assert rst 2 cycles with id_valid=1 → alu_enable=0, alu_aluctrl=0, ex_we=0, bubble_cnt=0.
- EX/MEM forward: ADD r3 in MEM (mem_rd=3, mem_result=0x0000_00AA, mem_we=1), EX reads rs1=3 with regfile data 0x11 → alu_src1=0xAA. Then drop mem_we with wb_rd=3, wb_data=0x55 → alu_src1=0x55.
- Load-use: LW r5 captured, next id has rs1=5 → stall_id=1 for exactly 1 cycle, EX bubble (alu_enable=0), bubble_cnt=1. The consumer then enters EX with alu_src1=wb_data.
- Flush: branch_true=1 with id_valid=1 → next cycle alu_enable=0, ex_we=0. With lu_hazard set in the same cycle → stall_id=0, bubble_cnt unchanged.
- mem_stall: hold 3 cycles while id_* changes → alu_* outputs unchanged and stall_id=1. A branch_true asserted during the stall flushes only on the first cycle after mem_stall drops.
- r0 and saturation:
  - rs1=0 with mem_rd=0, mem_we=1, mem_result=0xFFFF → alu_src1=0.
  - Force 65536 bubbles → bubble_cnt=0xFFFF and stays there.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipe_pkg                                               |
// | Description : Shared widths, ALU control codes and the ID/EX         |
// |               pipeline register layout.                              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package pipe_pkg;

  localparam int REG_BUS_W    = 32;  // RegBus
  localparam int INST_ADDR_W  = 32;  // InstAddrBus
  localparam int ALU_CTRL_W   = 5;   // AluCtrl
  localparam int REG_IDX_BITS = 5;

  typedef enum logic [ALU_CTRL_W-1:0] {
    AluCtrlNop  = 5'd0,
    AluCtrlAdd  = 5'd1,
    AluCtrlSub  = 5'd2,
    AluCtrlAnd  = 5'd3,
    AluCtrlOr   = 5'd4,
    AluCtrlXor  = 5'd5,
    AluCtrlSll  = 5'd6,
    AluCtrlSrl  = 5'd7,
    AluCtrlSra  = 5'd8,
    AluCtrlSlt  = 5'd9,
    AluCtrlSltu = 5'd10,
    AluCtrlBeq  = 5'd11,
    AluCtrlJal  = 5'd12
  } alu_ctrl_e;

  // Contents of the ID/EX pipeline register. An all-zero value is a bubble.
  typedef struct packed {
    logic                    valid;
    logic [ALU_CTRL_W-1:0]   aluctrl;
    logic [REG_IDX_BITS-1:0] rs1;
    logic [REG_IDX_BITS-1:0] rs2;
    logic [REG_BUS_W-1:0]    rs1_data;
    logic [REG_BUS_W-1:0]    rs2_data;
    logic [REG_BUS_W-1:0]    imm;
    logic                    use_imm;
    logic [REG_IDX_BITS-1:0] rd;
    logic                    we;
    logic                    is_load;
    logic [INST_ADDR_W-1:0]  pc;
    logic [INST_ADDR_W-1:0]  branch_off;
  } id_ex_t;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : id_ex_stage_if                                         |
// | Description : Decoder, bypass, ALU and hazard signals around the     |
// |               ID/EX stage. master = surrounding pipeline, slave =    |
// |               the stage itself.                                      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface id_ex_stage_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ALUCTRL_W = 5,
  parameter int REG_IDX_W = 5,
  parameter int CNT_W     = 16
);
  // decoder / register file
  logic                 id_valid;
  logic [ALUCTRL_W-1:0] id_aluctrl;
  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic [DATA_W-1:0]    id_rs1_data;
  logic [DATA_W-1:0]    id_rs2_data;
  logic [DATA_W-1:0]    id_imm;
  logic                 id_use_imm;
  logic [REG_IDX_W-1:0] id_rd;
  logic                 id_we;
  logic                 id_is_load;
  logic [ADDR_W-1:0]    id_pc;
  logic [ADDR_W-1:0]    id_branch_off;
  // bypass sources
  logic [REG_IDX_W-1:0] mem_rd;
  logic                 mem_we;
  logic                 mem_is_load;
  logic [DATA_W-1:0]    mem_result;
  logic [REG_IDX_W-1:0] wb_rd;
  logic                 wb_we;
  logic [DATA_W-1:0]    wb_data;
  // pipeline control
  logic                 mem_stall;
  logic                 branch_true;
  logic                 stall_id;
  // EX side
  logic                 alu_enable;
  logic [ALUCTRL_W-1:0] alu_aluctrl;
  logic [DATA_W-1:0]    alu_src1;
  logic [DATA_W-1:0]    alu_src2;
  logic [ADDR_W-1:0]    alu_pc_o;
  logic [ADDR_W-1:0]    alu_branch_addr;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_we;
  logic                 ex_is_load;
  logic [DATA_W-1:0]    ex_store_data;
  logic [CNT_W-1:0]     bubble_cnt;

  modport master (
    output id_valid, id_aluctrl, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
           id_imm, id_use_imm, id_rd, id_we, id_is_load, id_pc, id_branch_off,
           mem_rd, mem_we, mem_is_load, mem_result, wb_rd, wb_we, wb_data,
           mem_stall, branch_true,
    input  stall_id, alu_enable, alu_aluctrl, alu_src1, alu_src2, alu_pc_o,
           alu_branch_addr, ex_rd, ex_we, ex_is_load, ex_store_data, bubble_cnt
  );

  modport slave (
    input  id_valid, id_aluctrl, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
           id_imm, id_use_imm, id_rd, id_we, id_is_load, id_pc, id_branch_off,
           mem_rd, mem_we, mem_is_load, mem_result, wb_rd, wb_we, wb_data,
           mem_stall, branch_true,
    output stall_id, alu_enable, alu_aluctrl, alu_src1, alu_src2, alu_pc_o,
           alu_branch_addr, ex_rd, ex_we, ex_is_load, ex_store_data, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fwd_unit                                               |
// | Description : Bypass mux for one source operand of the EX stage.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module fwd_unit #(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic [REG_IDX_W-1:0] rs_i,
  input  logic [DATA_W-1:0]    rf_data_i,
  input  logic [REG_IDX_W-1:0] mem_rd_i,
  input  logic                 mem_we_i,
  input  logic                 mem_is_load_i,
  input  logic [DATA_W-1:0]    mem_result_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  input  logic                 wb_we_i,
  input  logic [DATA_W-1:0]    wb_data_i,
  output logic [DATA_W-1:0]    data_o
);

  // r0 reads zero; otherwise take the youngest producer, MEM ahead of WB.
  // A load in MEM has no data yet, so it is skipped (the interlock keeps
  // that case out of EX anyway).
  always_comb begin
    data_o = rf_data_i;
    if (rs_i == '0) begin
      data_o = '0;
    end else if (mem_we_i && !mem_is_load_i && (mem_rd_i == rs_i)) begin
      data_o = mem_result_i;
    end else if (wb_we_i && (wb_rd_i == rs_i)) begin
      data_o = wb_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : id_ex_stage                                            |
// | Description : ID/EX pipeline register with operand forwarding,       |
// |               load-use interlock, branch flush and a saturating      |
// |               bubble counter.                                        |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W    = REG_BUS_W,
  parameter int ADDR_W    = INST_ADDR_W,
  parameter int ALUCTRL_W = ALU_CTRL_W,
  parameter int REG_IDX_W = REG_IDX_BITS,
  parameter int CNT_W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus_io
);

  id_ex_t             ex_q, ex_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;
  logic               lu_hazard;
  logic [DATA_W-1:0]  fwd_rs1, fwd_rs2;

  // The load in EX has no result until MEM, so a consumer directly behind
  // it must wait one cycle.
  assign lu_hazard = ex_q.valid && ex_q.is_load && ex_q.we && (ex_q.rd != '0) &&
                     bus_io.id_valid &&
                     ((bus_io.id_rs1 == ex_q.rd) ||
                      (!bus_io.id_use_imm && (bus_io.id_rs2 == ex_q.rd)));

  // A flush discards the consumer, so no stall is needed in that case.
  assign bus_io.stall_id = (lu_hazard && !bus_io.branch_true) || bus_io.mem_stall;

  // Next-state selection: hold > flush > load-use bubble > capture.
  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus_io.mem_stall) begin
      ex_d = ex_q;
    end else if (bus_io.branch_true) begin
      ex_d         = '0;
      ex_d.aluctrl = AluCtrlNop;
    end else if (lu_hazard) begin
      ex_d         = '0;
      ex_d.aluctrl = AluCtrlNop;
      if (~&bubble_cnt_q) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end else begin
      ex_d.valid      = bus_io.id_valid;
      ex_d.aluctrl    = bus_io.id_aluctrl;
      ex_d.rs1        = bus_io.id_rs1;
      ex_d.rs2        = bus_io.id_rs2;
      ex_d.rs1_data   = bus_io.id_rs1_data;
      ex_d.rs2_data   = bus_io.id_rs2_data;
      ex_d.imm        = bus_io.id_imm;
      ex_d.use_imm    = bus_io.id_use_imm;
      ex_d.rd         = bus_io.id_rd;
      ex_d.we         = bus_io.id_we;
      ex_d.is_load    = bus_io.id_is_load;
      ex_d.pc         = bus_io.id_pc;
      ex_d.branch_off = bus_io.id_branch_off;
    end
  end

  // Pipeline register and bubble counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  fwd_unit #(.DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W)) u_fwd_rs1 (
    .rs_i          (ex_q.rs1),
    .rf_data_i     (ex_q.rs1_data),
    .mem_rd_i      (bus_io.mem_rd),
    .mem_we_i      (bus_io.mem_we),
    .mem_is_load_i (bus_io.mem_is_load),
    .mem_result_i  (bus_io.mem_result),
    .wb_rd_i       (bus_io.wb_rd),
    .wb_we_i       (bus_io.wb_we),
    .wb_data_i     (bus_io.wb_data),
    .data_o        (fwd_rs1)
  );

  fwd_unit #(.DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W)) u_fwd_rs2 (
    .rs_i          (ex_q.rs2),
    .rf_data_i     (ex_q.rs2_data),
    .mem_rd_i      (bus_io.mem_rd),
    .mem_we_i      (bus_io.mem_we),
    .mem_is_load_i (bus_io.mem_is_load),
    .mem_result_i  (bus_io.mem_result),
    .wb_rd_i       (bus_io.wb_rd),
    .wb_we_i       (bus_io.wb_we),
    .wb_data_i     (bus_io.wb_data),
    .data_o        (fwd_rs2)
  );

  assign bus_io.alu_enable      = ex_q.valid;
  assign bus_io.alu_aluctrl     = ALUCTRL_W'(ex_q.aluctrl);
  assign bus_io.alu_src1        = fwd_rs1;
  assign bus_io.alu_src2        = ex_q.use_imm ? ex_q.imm : fwd_rs2;
  assign bus_io.ex_store_data   = fwd_rs2;
  assign bus_io.alu_pc_o        = ADDR_W'(ex_q.pc);
  assign bus_io.alu_branch_addr = ADDR_W'(ex_q.branch_off);
  assign bus_io.ex_rd           = ex_q.rd;
  assign bus_io.ex_we           = ex_q.we;
  assign bus_io.ex_is_load      = ex_q.is_load;
  assign bus_io.bubble_cnt      = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_id_ex_stage                                         |
// | Description : Directed and random checks of id_ex_stage against a    |
// |               behavioural model of the ID/EX stage.                  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_id_ex_stage;

  // Narrow counter so saturation is reachable in a short run.
  localparam int CNT_W   = 12;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.CNT_W(CNT_W)) bus ();

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // Model of what the EX stage currently holds.
  bit          m_valid, m_use, m_we, m_ld;
  logic [4:0]  m_ctrl, m_rs1, m_rs2, m_rd;
  logic [31:0] m_rs1d, m_rs2d, m_imm, m_pc, m_off;
  int          m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_haz();
    return m_valid && m_ld && m_we && (m_rd != 0) && bus.id_valid &&
           ((bus.id_rs1 == m_rd) || (!bus.id_use_imm && (bus.id_rs2 == m_rd)));
  endfunction

  function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] d);
    if (r == 0) return 32'h0;
    if (bus.mem_we && !bus.mem_is_load && (bus.mem_rd == r)) return bus.mem_result;
    if (bus.wb_we && (bus.wb_rd == r)) return bus.wb_data;
    return d;
  endfunction

  task automatic model_bubble();
    m_valid = 0; m_ctrl = 0; m_we = 0; m_ld = 0; m_use = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rs1d = 0; m_rs2d = 0;
    m_imm = 0; m_pc = 0; m_off = 0;
  endtask

  // Advance model and DUT across one rising edge; returns 1 ns after it.
  task automatic tick();
    if (rst) begin
      model_bubble();
      m_cnt = 0;
    end else if (bus.mem_stall) begin
      // hold
    end else if (bus.branch_true) begin
      model_bubble();
    end else if (model_haz()) begin
      model_bubble();
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_valid = bus.id_valid;   m_ctrl = bus.id_aluctrl; m_rs1 = bus.id_rs1;
      m_rs2   = bus.id_rs2;     m_rs1d = bus.id_rs1_data; m_rs2d = bus.id_rs2_data;
      m_imm   = bus.id_imm;     m_use  = bus.id_use_imm; m_rd = bus.id_rd;
      m_we    = bus.id_we;      m_ld   = bus.id_is_load; m_pc = bus.id_pc;
      m_off   = bus.id_branch_off;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".stall_id"},   64'(bus.stall_id),
        64'((model_haz() && !bus.branch_true) || bus.mem_stall));
    chk({tag, ".alu_enable"}, 64'(bus.alu_enable), 64'(m_valid));
    chk({tag, ".aluctrl"},    64'(bus.alu_aluctrl), 64'(m_ctrl));
    chk({tag, ".src1"},       64'(bus.alu_src1), 64'(mfwd(m_rs1, m_rs1d)));
    chk({tag, ".src2"},       64'(bus.alu_src2), 64'(m_use ? m_imm : mfwd(m_rs2, m_rs2d)));
    chk({tag, ".store"},      64'(bus.ex_store_data), 64'(mfwd(m_rs2, m_rs2d)));
    chk({tag, ".pc"},         64'(bus.alu_pc_o), 64'(m_pc));
    chk({tag, ".boff"},       64'(bus.alu_branch_addr), 64'(m_off));
    chk({tag, ".ex_rd"},      64'(bus.ex_rd), 64'(m_rd));
    chk({tag, ".ex_we"},      64'(bus.ex_we), 64'(m_we));
    chk({tag, ".ex_ld"},      64'(bus.ex_is_load), 64'(m_ld));
    chk({tag, ".bubble_cnt"}, 64'(bus.bubble_cnt), 64'(m_cnt));
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_aluctrl = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_use_imm = 0;
    bus.id_rd = 0; bus.id_we = 0; bus.id_is_load = 0; bus.id_pc = 0;
    bus.id_branch_off = 0;
    bus.mem_rd = 0; bus.mem_we = 0; bus.mem_is_load = 0; bus.mem_result = 0;
    bus.wb_rd = 0; bus.wb_we = 0; bus.wb_data = 0;
    bus.mem_stall = 0; bus.branch_true = 0;
  endtask

  task automatic set_id(input logic [4:0] ctrl, input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rd, input bit we, input bit ld);
    bus.id_valid = 1; bus.id_aluctrl = ctrl; bus.id_rs1 = rs1; bus.id_rs1_data = d1;
    bus.id_rs2 = 5'd4; bus.id_rs2_data = 32'h22; bus.id_use_imm = 0;
    bus.id_imm = 32'h0000_0100; bus.id_rd = rd; bus.id_we = we; bus.id_is_load = ld;
    bus.id_pc = 32'h0000_1000; bus.id_branch_off = 32'h0000_0040;
  endtask

  initial begin
    model_bubble();
    m_cnt = 0;
    idle();

    // Reset held for two cycles while the decoder shows a valid op.
    bus.id_valid = 1; bus.id_aluctrl = 5'd3; rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst.alu_enable", 64'(bus.alu_enable), 64'd0);
    chk("rst.aluctrl",    64'(bus.alu_aluctrl), 64'd0);
    chk("rst.ex_we",      64'(bus.ex_we), 64'd0);
    chk("rst.bubble_cnt", 64'(bus.bubble_cnt), 64'd0);

    // EX/MEM then MEM/WB forwarding on rs1 = 3.
    idle();
    set_id(5'd1, 5'd3, 32'h11, 5'd6, 1, 0);
    tick();
    bus.mem_rd = 5'd3; bus.mem_we = 1; bus.mem_result = 32'h0000_00AA;
    #1;
    chk("fwd_mem.src1", 64'(bus.alu_src1), 64'h0000_00AA);
    check_all("fwd_mem");
    bus.mem_we = 0; bus.wb_rd = 5'd3; bus.wb_we = 1; bus.wb_data = 32'h55;
    #1;
    chk("fwd_wb.src1", 64'(bus.alu_src1), 64'h55);
    check_all("fwd_wb");

    // Load-use: LW r5 then a consumer of r5.
    idle();
    set_id(5'd1, 5'd2, 32'h0, 5'd5, 1, 1);
    tick();
    set_id(5'd2, 5'd5, 32'hDEAD, 5'd7, 1, 0);
    #1;
    chk("lu.stall_id", 64'(bus.stall_id), 64'd1);
    tick();
    chk("lu.bubble_enable", 64'(bus.alu_enable), 64'd0);
    chk("lu.bubble_cnt",    64'(bus.bubble_cnt), 64'd1);
    chk("lu.stall_released", 64'(bus.stall_id), 64'd0);
    bus.wb_rd = 5'd5; bus.wb_we = 1; bus.wb_data = 32'h0000_1234;
    tick();
    chk("lu.consumer_enable", 64'(bus.alu_enable), 64'd1);
    chk("lu.consumer_src1",   64'(bus.alu_src1), 64'h0000_1234);
    check_all("lu.consumer");

    // Flush coinciding with a load-use hazard.
    idle();
    set_id(5'd1, 5'd2, 32'h0, 5'd5, 1, 1);
    tick();
    set_id(5'd2, 5'd5, 32'h0, 5'd7, 1, 0);
    bus.branch_true = 1;
    #1;
    chk("flush.stall_id", 64'(bus.stall_id), 64'd0);
    tick();
    chk("flush.alu_enable", 64'(bus.alu_enable), 64'd0);
    chk("flush.ex_we",      64'(bus.ex_we), 64'd0);
    chk("flush.bubble_cnt", 64'(bus.bubble_cnt), 64'd1);

    // mem_stall for three cycles, with a branch raised mid-stall.
    idle();
    set_id(5'd2, 5'd8, 32'h80, 5'd9, 1, 0);
    tick();
    bus.mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.id_aluctrl = 5'($urandom_range(3, 12));
      bus.id_rs1     = 5'($urandom_range(10, 31));
      bus.id_pc      = $urandom;
      if (i == 1) bus.branch_true = 1;
      #1;
      chk("stall.stall_id", 64'(bus.stall_id), 64'd1);
      tick();
      chk("stall.aluctrl",    64'(bus.alu_aluctrl), 64'd2);
      chk("stall.alu_enable", 64'(bus.alu_enable), 64'd1);
      chk("stall.src1",       64'(bus.alu_src1), 64'h80);
    end
    bus.mem_stall = 0;
    #1;
    chk("stall.release_stall_id", 64'(bus.stall_id), 64'd0);
    tick();
    bus.branch_true = 0;
    chk("stall.late_flush", 64'(bus.alu_enable), 64'd0);

    // r0 never forwards.
    idle();
    set_id(5'd1, 5'd0, 32'h77, 5'd1, 1, 0);
    tick();
    bus.mem_rd = 5'd0; bus.mem_we = 1; bus.mem_result = 32'h0000_FFFF;
    bus.wb_rd = 5'd0; bus.wb_we = 1; bus.wb_data = 32'h0000_5555;
    #1;
    chk("r0.src1", 64'(bus.alu_src1), 64'd0);

    // Self-dependent load repeated: one bubble every two cycles.
    idle();
    set_id(5'd1, 5'd5, 32'h0, 5'd5, 1, 1);
    for (int i = 0; i < 2 * CNT_MAX + 8; i++) tick();
    chk("sat.bubble_cnt", 64'(bus.bubble_cnt), 64'(CNT_MAX));
    for (int i = 0; i < 6; i++) tick();
    chk("sat.hold", 64'(bus.bubble_cnt), 64'(CNT_MAX));
    check_all("sat");

    // Reset arriving during a stall.
    bus.mem_stall = 1; rst = 1;
    tick();
    rst = 0; bus.mem_stall = 0;
    chk("rst_stall.alu_enable", 64'(bus.alu_enable), 64'd0);
    chk("rst_stall.bubble_cnt", 64'(bus.bubble_cnt), 64'd0);

    // Random traffic on a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      bus.id_valid      = ($urandom_range(0, 9) != 0);
      bus.id_aluctrl    = 5'($urandom_range(0, 12));
      bus.id_rs1        = 5'($urandom_range(0, 5));
      bus.id_rs2        = 5'($urandom_range(0, 5));
      bus.id_rs1_data   = $urandom;
      bus.id_rs2_data   = $urandom;
      bus.id_imm        = $urandom;
      bus.id_use_imm    = 1'($urandom_range(0, 1));
      bus.id_rd         = 5'($urandom_range(0, 5));
      bus.id_we         = ($urandom_range(0, 3) != 0);
      bus.id_is_load    = ($urandom_range(0, 2) == 0);
      bus.id_pc         = $urandom;
      bus.id_branch_off = $urandom;
      bus.mem_rd        = 5'($urandom_range(0, 5));
      bus.mem_we        = 1'($urandom_range(0, 1));
      bus.mem_is_load   = ($urandom_range(0, 3) == 0);
      bus.mem_result    = $urandom;
      bus.wb_rd         = 5'($urandom_range(0, 5));
      bus.wb_we         = 1'($urandom_range(0, 1));
      bus.wb_data       = $urandom;
      bus.mem_stall     = ($urandom_range(0, 7) == 0);
      bus.branch_true   = ($urandom_range(0, 9) == 0);
      rst               = ($urandom_range(0, 99) == 0);
      #1;
      check_all("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
